seq_gen_cmd_driver: RTL and testbench

Upstream command stage for sequence_gen. It accepts calculation commands over a valid/ready interface and drives the sequence_gen inputs with a legal protocol: one-hot mode, a 2-cycle load, and stable order/data_in. It then waits for done, overflow or error, bounded by a timeout, and returns one tagged response per command. After each response is taken it issues a 1-cycle clear.

---
 rtl/seq_gen_cmd_driver.sv | 172 +++++++++++++++++
 tb/tb_seq_gen_cmd_driver.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_cmd_driver.sv
// Command front-end for sequence_gen: accepts tagged commands, sequences load/mode/order,
// waits for completion or timeout, returns one response and then pulses clear.
// Optional build macro: SEQ_GEN_CMD_DRIVER_ORDER_CHECK_EN (rejects order-0 commands at accept).
module seq_gen_cmd_driver #(
    parameter int DATA_W        = 64,
    parameter int ORDER_W       = 16,
    parameter int TIMEOUT_SLACK = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_mode_i,
    input  logic [ORDER_W-1:0] cmd_order_i,
    input  logic [DATA_W-1:0]  cmd_data_i,
    output logic               fibonacci_o,
    output logic               triangle_o,
    output logic               load_o,
    output logic               clear_o,
    output logic [ORDER_W-1:0] order_o,
    output logic [DATA_W-1:0]  data_in_o,
    input  logic               done_i,
    input  logic [DATA_W-1:0]  data_out_i,
    input  logic               overflow_i,
    input  logic               error_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DATA_W-1:0]  rsp_data_o,
    output logic [1:0]         rsp_status_o,
    output logic               busy_o
);

    // state | meaning
    // IDLE  | ready for a command
    // LOAD1 | first load cycle, counter starts at 0
    // LOAD2 | second load cycle
    // WAIT  | sample error/overflow/done, watch for timeout
    // RESP  | hold response until rsp_ready
    // CLEAR | one-cycle clear to sequence_gen
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD1, S_LOAD2, S_WAIT, S_RESP, S_CLEAR
    } state_t;

    localparam int               CNT_W   = ORDER_W + 4;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_EXT = CNT_W'(TIMEOUT_SLACK + 2);
    localparam logic [1:0]       ST_OK   = 2'b00;
    localparam logic [1:0]       ST_OVF  = 2'b01;
    localparam logic [1:0]       ST_ERR  = 2'b10;
    localparam logic [1:0]       ST_TMO  = 2'b11;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ORDER_W-1:0]  ord_q, ord_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, limit;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_status_q, rsp_status_d;
    logic                accept, reject, active_d;

    assign accept = cmd_valid_i && cmd_ready_o;
`ifdef SEQ_GEN_CMD_DRIVER_ORDER_CHECK_EN
    assign reject = accept && (cmd_order_i == '0);
`else
    assign reject = 1'b0;
`endif
    assign limit        = {4'b0000, ord_q} + CNT_EXT;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        ord_d        = ord_q;
        dat_d        = dat_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        case (state_q)
            S_IDLE: begin
                if (reject) begin
                    state_d      = S_RESP;
                    rsp_status_d = ST_ERR;
                    rsp_data_d   = '0;
                end else if (accept) begin
                    state_d = S_LOAD1;
                    mode_d  = cmd_mode_i;
                    ord_d   = cmd_order_i;
                    dat_d   = cmd_data_i;
                    cnt_d   = '0;
                end
            end
            S_LOAD1: begin
                state_d = S_LOAD2;
                cnt_d   = cnt_q + CNT_ONE;
            end
            S_LOAD2: begin
                state_d = S_WAIT;
                cnt_d   = cnt_q + CNT_ONE;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                // data_out is only trusted on overflow/done; error never forwards it
                if (error_i) begin
                    state_d = S_RESP; rsp_status_d = ST_ERR; rsp_data_d = '0;
                end else if (overflow_i) begin
                    state_d = S_RESP; rsp_status_d = ST_OVF; rsp_data_d = data_out_i;
                end else if (done_i) begin
                    state_d = S_RESP; rsp_status_d = ST_OK;  rsp_data_d = data_out_i;
                end else if (cnt_q == limit) begin
                    state_d = S_RESP; rsp_status_d = ST_TMO; rsp_data_d = '0;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d      = S_CLEAR;
                    rsp_data_d   = '0;
                    rsp_status_d = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
                mode_d  = 1'b0;
                ord_d   = '0;
                dat_d   = '0;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        active_d = (state_d == S_LOAD1) || (state_d == S_LOAD2) || (state_d == S_WAIT);
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            ord_q        <= '0;
            dat_q        <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            cmd_ready_o  <= 1'b0;
            fibonacci_o  <= 1'b0;
            triangle_o   <= 1'b0;
            load_o       <= 1'b0;
            clear_o      <= 1'b0;
            order_o      <= '0;
            data_in_o    <= '0;
            rsp_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            ord_q        <= ord_d;
            dat_q        <= dat_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            cmd_ready_o  <= (state_d == S_IDLE);
            fibonacci_o  <= active_d && !mode_d;
            triangle_o   <= active_d && mode_d;
            load_o       <= (state_d == S_LOAD1) || (state_d == S_LOAD2);
            clear_o      <= (state_d == S_CLEAR);
            order_o      <= active_d ? ord_d : '0;
            data_in_o    <= active_d ? dat_d : '0;
            rsp_valid_o  <= (state_d == S_RESP);
            busy_o       <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_seq_gen_cmd_driver.sv
// Self-checking bench for seq_gen_cmd_driver: directed scenarios plus randomized commands
// compared against a cycle-count reference model of the command/response rules.
module tb_seq_gen_cmd_driver;
    localparam int DW    = 64;
    localparam int OW    = 16;
    localparam int SLACK = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready_o, cmd_mode;
    logic [OW-1:0] cmd_order;
    logic [DW-1:0] cmd_data;
    logic          fibonacci_o, triangle_o, load_o, clear_o;
    logic [OW-1:0] order_o;
    logic [DW-1:0] data_in_o;
    logic          done, overflow, error;
    logic [DW-1:0] data_out;
    logic          rsp_valid_o, rsp_ready;
    logic [DW-1:0] rsp_data_o;
    logic [1:0]    rsp_status_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    int            exp_lat;
    logic [1:0]    exp_status;
    logic [DW-1:0] exp_data;

    int            obs_lat, obs_load_cnt, obs_drive_err, obs_hold_err, obs_clear_cnt, obs_hs_err, obs_x_err;
    bit            obs_timeout;
    logic [1:0]    obs_status;
    logic [DW-1:0] obs_data;

    seq_gen_cmd_driver #(.DATA_W(DW), .ORDER_W(OW), .TIMEOUT_SLACK(SLACK)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_mode_i(cmd_mode),
        .cmd_order_i(cmd_order), .cmd_data_i(cmd_data),
        .fibonacci_o(fibonacci_o), .triangle_o(triangle_o), .load_o(load_o), .clear_o(clear_o),
        .order_o(order_o), .data_in_o(data_in_o),
        .done_i(done), .data_out_i(data_out), .overflow_i(overflow), .error_i(error),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // kind: 0 done, 1 overflow, 2 error, 3 error+done together, 4 never completes.
    // at_j is the WAIT cycle (0 = first) in which the completion is offered.
    task automatic model(input int kind, input int at_j, input int ord, input logic [DW-1:0] dout);
        int lim;
        lim = ord + SLACK;
        if (kind == 4 || at_j > lim) begin
            exp_status = 2'b11; exp_data = '0; exp_lat = 3 + lim;
        end else begin
            exp_lat = 3 + at_j;
            case (kind)
                0:       begin exp_status = 2'b00; exp_data = dout; end
                1:       begin exp_status = 2'b01; exp_data = dout; end
                default: begin exp_status = 2'b10; exp_data = '0;   end
            endcase
        end
    endtask

    // Runs one command through to the cycle after clear and records what was seen.
    task automatic drive_cmd(input logic mode, input logic [OW-1:0] ord, input logic [DW-1:0] dat,
                             input int kind, input int at_j, input int rdelay, input bit load_pulse,
                             input logic [DW-1:0] dout);
        int c;
        bit got;
        bit bad;
        obs_lat = -1; obs_load_cnt = 0; obs_drive_err = 0; obs_hold_err = 0;
        obs_clear_cnt = 0; obs_hs_err = 0; obs_x_err = 0; obs_timeout = 0;
        obs_status = '0; obs_data = '0;
        for (int w = 0; w < 20 && cmd_ready_o !== 1'b1; w++) @(negedge clk);
        if (cmd_ready_o !== 1'b1) begin obs_timeout = 1; return; end
        cmd_valid = 1'b1; cmd_mode = mode; cmd_order = ord; cmd_data = dat;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_mode = 1'($urandom); cmd_order = OW'($urandom);
        cmd_data = {$urandom, $urandom};
        c = 1;
        got = 0;
        while (!got && c < 60) begin
            if ($isunknown({cmd_ready_o, fibonacci_o, triangle_o, load_o, clear_o, order_o,
                            data_in_o, rsp_valid_o, rsp_data_o, rsp_status_o, busy_o})) obs_x_err++;
            if (clear_o === 1'b1) obs_clear_cnt++;
            if (rsp_valid_o === 1'b1) begin
                got = 1;
                obs_lat = c - 1; obs_status = rsp_status_o; obs_data = rsp_data_o;
                if (fibonacci_o !== 1'b0 || triangle_o !== 1'b0 || load_o !== 1'b0 ||
                    order_o !== '0 || data_in_o !== '0 || busy_o !== 1'b1 || cmd_ready_o !== 1'b0)
                    obs_drive_err++;
            end else begin
                if (load_o === 1'b1) obs_load_cnt++;
                if (c <= exp_lat)
                    bad = fibonacci_o !== ~mode || triangle_o !== mode || order_o !== ord ||
                          data_in_o !== dat || busy_o !== 1'b1 || cmd_ready_o !== 1'b0 ||
                          load_o !== 1'(c <= 2);
                else
                    bad = fibonacci_o !== 1'b0 || triangle_o !== 1'b0 || load_o !== 1'b0 ||
                          order_o !== '0 || data_in_o !== '0;
                if (bad) obs_drive_err++;
                done = 1'b0; overflow = 1'b0; error = 1'b0; data_out = {$urandom, $urandom};
                if (load_pulse && c == 1) begin done = 1'b1; overflow = 1'b1; error = 1'b1; end
                if (c == 3 + at_j) begin
                    case (kind)
                        0: begin done = 1'b1; data_out = dout; end
                        1: begin overflow = 1'b1; data_out = dout; end
                        2: begin error = 1'b1; data_out = 'x; end
                        3: begin error = 1'b1; done = 1'b1; data_out = 'x; end
                        default: ;
                    endcase
                end
                c++;
                @(negedge clk);
            end
        end
        done = 1'b0; overflow = 1'b0; error = 1'b0; data_out = '0;
        if (!got) begin obs_timeout = 1; return; end
        for (int d = 0; d < rdelay; d++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_status_o !== obs_status || rsp_data_o !== obs_data ||
                cmd_ready_o !== 1'b0 || clear_o !== 1'b0 || load_o !== 1'b0 || busy_o !== 1'b1)
                obs_hold_err++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (clear_o === 1'b1) obs_clear_cnt++;
        if (clear_o !== 1'b1 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b0) obs_hs_err++;
        @(negedge clk);
        if (clear_o === 1'b1) obs_clear_cnt++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0) obs_hs_err++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_order = '0; cmd_data = '0;
        done = 1'b0; overflow = 1'b0; error = 1'b0; data_out = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready_o, fibonacci_o, triangle_o, load_o, clear_o, order_o, data_in_o,
             rsp_valid_o, rsp_data_o, rsp_status_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b busy=%b load=%b rsp_valid=%b required all 0",
                     cmd_ready_o, busy_o, load_o, rsp_valid_o);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b required ready=1 busy=0", cmd_ready_o, busy_o);
        end
    endtask

    task automatic test_fib_done();
        model(0, 4, 5, 64'd8);
        drive_cmd(1'b0, 16'd5, 64'd1, 0, 4, 0, 0, 64'd8);
        checks++;
        if (obs_status !== exp_status || obs_data !== exp_data || obs_lat != exp_lat) begin
            errors++;
            $display("FAIL fib_done got st=%b data=%h lat=%0d required st=%b data=%h lat=%0d",
                     obs_status, obs_data, obs_lat, exp_status, exp_data, exp_lat);
        end
        checks++;
        if (obs_load_cnt != 2 || obs_drive_err != 0 || obs_clear_cnt != 1 || obs_hs_err != 0 || obs_timeout) begin
            errors++;
            $display("FAIL fib_protocol got load=%0d drv=%0d clr=%0d hs=%0d to=%0d required 2 0 1 0 0",
                     obs_load_cnt, obs_drive_err, obs_clear_cnt, obs_hs_err, obs_timeout);
        end
    endtask

    task automatic test_overflow();
        model(1, 1, 3, '1);
        drive_cmd(1'b1, 16'd3, {$urandom, $urandom}, 1, 1, 0, 0, '1);
        checks++;
        if (obs_status !== 2'b01 || obs_data !== 64'hFFFF_FFFF_FFFF_FFFF || obs_lat != exp_lat ||
            obs_drive_err != 0 || obs_load_cnt != 2) begin
            errors++;
            $display("FAIL tri_overflow got st=%b data=%h lat=%0d drv=%0d load=%0d required st=01 data=all1 lat=%0d drv=0 load=2",
                     obs_status, obs_data, obs_lat, obs_drive_err, obs_load_cnt, exp_lat);
        end
    endtask

    task automatic test_error_priority();
        // every completion input also pulses during LOAD1, which must be ignored
        model(3, 2, 4, '0);
        drive_cmd(1'b0, 16'd4, {$urandom, $urandom}, 3, 2, 0, 1, '0);
        checks++;
        if (obs_status !== 2'b10 || obs_data !== '0 || obs_lat != exp_lat) begin
            errors++;
            $display("FAIL err_priority got st=%b data=%h lat=%0d required st=10 data=0 lat=%0d",
                     obs_status, obs_data, obs_lat, exp_lat);
        end
        checks++;
        if (obs_x_err != 0 || obs_drive_err != 0 || obs_clear_cnt != 1) begin
            errors++;
            $display("FAIL err_outputs got x=%0d drv=%0d clr=%0d required 0 0 1", obs_x_err, obs_drive_err, obs_clear_cnt);
        end
    endtask

    task automatic test_timeout();
        model(4, 0, 3, '0);
        drive_cmd(1'b1, 16'd3, {$urandom, $urandom}, 4, 0, 0, 0, '0);
        checks++;
        if (obs_status !== 2'b11 || obs_data !== '0 || obs_lat != 3 + 3 + SLACK) begin
            errors++;
            $display("FAIL timeout got st=%b data=%h lat=%0d required st=11 data=0 lat=%0d",
                     obs_status, obs_data, obs_lat, 3 + 3 + SLACK);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] v;
        v = {$urandom, $urandom};
        model(0, 0, 2, v);
        drive_cmd(1'b0, 16'd2, {$urandom, $urandom}, 0, 0, 5, 0, v);
        checks++;
        if (obs_lat != 3 || obs_data !== v || obs_status !== 2'b00) begin
            errors++;
            $display("FAIL min_latency got lat=%0d st=%b data=%h required lat=3 st=00 data=%h",
                     obs_lat, obs_status, obs_data, v);
        end
        checks++;
        if (obs_hold_err != 0 || obs_clear_cnt != 1 || obs_hs_err != 0) begin
            errors++;
            $display("FAIL backpressure got hold=%0d clr=%0d hs=%0d required 0 1 0", obs_hold_err, obs_clear_cnt, obs_hs_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        for (int w = 0; w < 20 && cmd_ready_o !== 1'b1; w++) @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_order = 16'd6; cmd_data = 64'h55;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready_o, fibonacci_o, triangle_o, load_o, clear_o, order_o, data_in_o,
             rsp_valid_o, rsp_data_o, rsp_status_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait got busy=%b fib=%b order=%h required all outputs 0", busy_o, fibonacci_o, order_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || clear_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard got stray=%0d ready=%b busy=%b required 0 1 0", seen, cmd_ready_o, busy_o);
        end
        model(0, 1, 2, 64'd3);
        drive_cmd(1'b1, 16'd2, 64'd1, 0, 1, 0, 0, 64'd3);
        checks++;
        if (obs_status !== exp_status || obs_data !== exp_data || obs_lat != exp_lat || obs_drive_err != 0 || obs_clear_cnt != 1) begin
            errors++;
            $display("FAIL after_reset got st=%b data=%h lat=%0d drv=%0d clr=%0d required st=%b data=%h lat=%0d 0 1",
                     obs_status, obs_data, obs_lat, obs_drive_err, obs_clear_cnt, exp_status, exp_data, exp_lat);
        end
    endtask

    task automatic test_order_zero();
`ifdef SEQ_GEN_CMD_DRIVER_ORDER_CHECK_EN
        exp_status = 2'b10; exp_data = '0; exp_lat = 0;
        drive_cmd(1'b0, 16'd0, {$urandom, $urandom}, 0, 0, 2, 0, 64'd7);
        checks++;
        if (obs_status !== exp_status || obs_data !== exp_data || obs_lat != exp_lat ||
            obs_load_cnt != 0 || obs_drive_err != 0 || obs_clear_cnt != 1) begin
            errors++;
            $display("FAIL order_zero got st=%b data=%h lat=%0d load=%0d drv=%0d clr=%0d required st=10 data=0 lat=0 0 0 1",
                     obs_status, obs_data, obs_lat, obs_load_cnt, obs_drive_err, obs_clear_cnt);
        end
`else
        model(0, 0, 0, 64'd7);
        drive_cmd(1'b0, 16'd0, {$urandom, $urandom}, 0, 0, 2, 0, 64'd7);
        checks++;
        if (obs_status !== exp_status || obs_data !== exp_data || obs_lat != exp_lat ||
            obs_load_cnt != 2 || obs_drive_err != 0 || obs_clear_cnt != 1) begin
            errors++;
            $display("FAIL order_zero got st=%b data=%h lat=%0d load=%0d drv=%0d clr=%0d required st=%b data=%h lat=%0d 2 0 1",
                     obs_status, obs_data, obs_lat, obs_load_cnt, obs_drive_err, obs_clear_cnt,
                     exp_status, exp_data, exp_lat);
        end
`endif
    endtask

    task automatic test_random();
        logic          mode;
        logic [OW-1:0] ord;
        logic [DW-1:0] dat, dout;
        int            kind, at_j, rdelay;
        bit            lp;
        for (int n = 0; n < 16; n++) begin
            mode = 1'($urandom_range(0, 1));
            ord = OW'($urandom_range(1, 8));
            dat = {$urandom, $urandom};
            dout = {$urandom, $urandom};
            kind = $urandom_range(0, 4);
            at_j = $urandom_range(0, int'(ord) + SLACK + 2);
            rdelay = $urandom_range(0, 4);
            lp = 1'($urandom_range(0, 1));
            model(kind, at_j, int'(ord), dout);
            drive_cmd(mode, ord, dat, kind, at_j, rdelay, lp, dout);
            checks++;
            if (obs_status !== exp_status || obs_data !== exp_data || obs_lat != exp_lat) begin
                errors++;
                $display("FAIL random[%0d] got st=%b data=%h lat=%0d required st=%b data=%h lat=%0d",
                         n, obs_status, obs_data, obs_lat, exp_status, exp_data, exp_lat);
            end
            checks++;
            if (obs_load_cnt != 2 || obs_drive_err != 0 || obs_hold_err != 0 || obs_clear_cnt != 1 ||
                obs_hs_err != 0 || obs_x_err != 0 || obs_timeout) begin
                errors++;
                $display("FAIL random_proto[%0d] got load=%0d drv=%0d hold=%0d clr=%0d hs=%0d x=%0d to=%0d required 2 0 0 1 0 0 0",
                         n, obs_load_cnt, obs_drive_err, obs_hold_err, obs_clear_cnt, obs_hs_err, obs_x_err, obs_timeout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fib_done();
        test_overflow();
        test_error_priority();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_order_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete, required completion before 400000");
        $fatal(1);
    end

endmodule
